mw_add_ctrl: RTL and testbench

MW_ADD_CTRL -- requirements
Module: mw_add_ctrl

---
 rtl/mw_add_ctrl.sv | 104 ++++++++++
 tb/tb_mw_add_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mw_add_ctrl.sv
// mw_add_ctrl: multi-word add/subtract that reuses one 16-bit carry slice, least-significant limb first.
module mw_add_ctrl #(
  parameter int NW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*NW-1:0] a,
  input  logic [16*NW-1:0] b,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16*NW-1:0] z,
  output logic            sign,
  output logic            zero,
  output logic            carry,
  output logic            parity,
  output logic            overflow,
  output logic            busy
);
  localparam int W = 16*NW;
  localparam int KW = $clog2(NW);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic c_q, c_d, nz_q, nz_d, odd_q, odd_d, ovf_q, ovf_d;
  logic [16:0] sum;
  logic done;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    c_d = c_q;
    a_d = a_q;
    b_d = b_q;
    z_d = z_q;
    nz_d = nz_q;
    odd_d = odd_q;
    ovf_d = ovf_q;
    sum = {1'b0, a_q[16*k_q +: 16]} + {1'b0, b_q[16*k_q +: 16]} + {16'b0, c_q};
    if (clr) state_d = IDLE;
    else case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = sub ? ~b : b;
        c_d = sub;
        k_d = '0;
        nz_d = 1'b0;
        odd_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        z_d[16*k_q +: 16] = sum[15:0];
        c_d = sum[16];
        nz_d = nz_q | (|sum[15:0]);
        odd_d = odd_q ^ (^sum[15:0]);
        k_d = k_q + KW'(1);
        if (k_q == KW'(NW-1)) begin
          state_d = DONE;
          k_d = '0;
          ovf_d = (a_q[W-1] == b_q[W-1]) && (sum[15] != a_q[W-1]);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      c_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
      nz_q <= 1'b0;
      odd_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      z_q <= z_d;
      nz_q <= nz_d;
      odd_q <= odd_d;
      ovf_q <= ovf_d;
    end
  end
  // flags read as zero until a complete result is presented
  assign done = state_q == DONE;
  assign in_ready = state_q == IDLE;
  assign out_valid = done;
  assign busy = !in_ready;
  assign z = z_q;
  assign sign = done & z_q[W-1];
  assign zero = done & ~nz_q;
  assign carry = done & c_q;
  assign parity = done & ~odd_q;
  assign overflow = done & ovf_q;
endmodule

// File: tb/tb_mw_add_ctrl.sv
// tb_mw_add_ctrl: scoreboard bench for mw_add_ctrl with NW=4.
module tb_mw_add_ctrl;
  localparam int NW = 4;
  localparam int W = 16*NW;
  typedef struct {
    logic [W-1:0] z;
    logic [4:0] f;
    int acc;
  } exp_t;
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 1, sub = 0;
  logic in_ready, out_valid, sign, zero, carry, parity, overflow, busy;
  logic [W-1:0] a = '0, b = '0, z;
  logic [4:0] flags;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  logic ov_prev = 0;
  mw_add_ctrl #(.NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .sign(sign), .zero(zero), .carry(carry), .parity(parity), .overflow(overflow), .busy(busy)
  );
  assign flags = {sign, zero, carry, parity, overflow};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    logic [W:0] r;
    logic c, v;
    r = s ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    c = s ? ~r[W] : r[W];
    v = s ? (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]) : (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    e.z = r[W-1:0];
    e.f = {r[W-1], r[W-1:0] == '0, c, ~^r[W-1:0], v};
    e.acc = 0;
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || clr) begin
      q.delete();
      ov_prev <= 0;
    end else begin
      if (in_valid && in_ready) begin
        e = model(a, b, sub);
        e.acc = cyc + 1;
        q.push_back(e);
      end
      if (out_valid && !ov_prev && q.size() != 0) check("latency", W'(cyc - q[0].acc), W'(NW));
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          check("z", z, e.z);
          check("flags", W'(flags), W'(e.f));
        end
      end
      ov_prev <= out_valid && !out_ready;
    end
  end
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1; a = x; b = y; sub = s;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("accept_timeout", W'(ok), 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_done;
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = q.size() == 0 && in_ready;
    end
    check("done_timeout", W'(ok), 1);
  endtask
  initial begin
    logic [W-1:0] zh;
    logic [4:0] fh;
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_state", W'({in_ready, out_valid, busy, flags}), W'(8'b1000_0000));
    check("rst_z", z, '0);
    @(posedge clk); #1 rst_n = 1;
    send(64'h0000_0000_0000_FFFF, 64'h1, 0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0);
    send(64'h5, 64'h7, 1);
    send(64'h8000_0000_0000_0000, 64'h1, 1);
    send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1);
    for (int i = 0; i < 6; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    wait_done();
    out_ready = 0;
    send(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("hold_reach_done", W'(seen), 1);
    zh = z; fh = flags;
    @(posedge clk); #1;
    in_valid = 1; a = 64'h55; b = 64'h66; sub = 0;
    repeat (3) begin
      @(negedge clk);
      check("hold_z", z, zh);
      check("hold_flags", W'(flags), W'(fh));
      check("hold_rdy_vld", W'({in_ready, out_valid}), W'(2'b01));
    end
    @(posedge clk); #1;
    out_ready = 1; in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check("release_idle", W'({in_ready, out_valid}), W'(2'b10));
    @(posedge clk); #1;
    clr = 1; in_valid = 1; a = 64'h3; b = 64'h4;
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    @(negedge clk);
    check("clr_blocks_accept", W'({in_ready, busy}), W'(2'b10));
    send(64'h1111, 64'h2222, 0);
    @(posedge clk);
    @(posedge clk); #1;
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    @(negedge clk);
    check("clr_run_idle", W'({in_ready, out_valid, busy}), W'(3'b100));
    repeat (6) @(negedge clk);
    check("clr_no_result", W'(out_valid), 0);
    send(64'h1, 64'h1, 0);
    wait_done();
    out_ready = 0;
    send(64'hABCD, 64'h1, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("rst_reach_done", W'(seen), 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("rst_async_state", W'({in_ready, out_valid, busy, flags}), W'(8'b1000_0000));
    check("rst_async_z", z, '0);
    @(posedge clk); #1;
    rst_n = 1; out_ready = 1;
    in_valid = 1; a = 64'h1; b = 64'h1; sub = 0;
    @(posedge clk); #1;
    in_valid = 0;
    check("accept_after_rst", W'(busy), 1);
    wait_done();
    check("final_z", z, 64'h2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
